// File: rtl/power_data_pkg.sv
// Shared types and constants for the power converter statistics frame logger.
package power_data_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_AVG = 2'd1,
    SEND_MIN = 2'd2,
    SEND_MAX = 2'd3
  } frame_state_t;

  localparam int BYTE_AVG    = 0;
  localparam int BYTE_MIN    = 1;
  localparam int BYTE_MAX    = 2;
  localparam int FRAME_BYTES = 3;

  // Min tracker starts all-ones and max tracker all-zeros, so the first sample wins both.
  localparam logic MIN_INIT_BIT = 1'b1;
  localparam logic MAX_INIT_BIT = 1'b0;

endpackage

// File: rtl/window_stats.sv
// Accumulates 2^LOG2_WIN accepted samples; done pulses combinationally with the
// window-completing sample, with avg/min/max already including that sample.
module window_stats
  import power_data_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              done,
  output logic [DATA_W-1:0] avg,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
);

  localparam int ACC_W = DATA_W + LOG2_WIN;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    sum;
  logic [LOG2_WIN-1:0] cnt_q;
  logic [DATA_W-1:0]   min_q;
  logic [DATA_W-1:0]   max_q;

  always_comb begin
    sum     = acc_q + ACC_W'(sample);
    min_val = (sample < min_q) ? sample : min_q;
    max_val = (sample > max_q) ? sample : max_q;
    avg     = sum[ACC_W-1:LOG2_WIN];
  end

  assign done = sample_valid && (cnt_q == {LOG2_WIN{1'b1}});

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      min_q <= {DATA_W{MIN_INIT_BIT}};
      max_q <= {DATA_W{MAX_INIT_BIT}};
    end else if (sample_valid) begin
      cnt_q <= cnt_q + LOG2_WIN'(1);
      if (done) begin
        acc_q <= '0;
        min_q <= {DATA_W{MIN_INIT_BIT}};
        max_q <= {DATA_W{MAX_INIT_BIT}};
      end else begin
        acc_q <= sum;
        min_q <= min_val;
        max_q <= max_val;
      end
    end
  end

endmodule

// File: rtl/power_frame_logger.sv
// Emits one 3-byte AVG/MIN/MAX frame per completed sample window over a valid/ready
// byte stream, with one pending frame slot and a sticky overrun flag for dropped windows.
module power_frame_logger
  import power_data_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              byte_ready,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              frame_first,
  output logic              frame_last,
  input  logic              clear_overrun,
  output logic              overrun
);

  logic              win_done;
  logic [DATA_W-1:0] win_avg;
  logic [DATA_W-1:0] win_min;
  logic [DATA_W-1:0] win_max;

  window_stats #(
    .DATA_W  (DATA_W),
    .LOG2_WIN(LOG2_WIN)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample      (sample),
    .done        (win_done),
    .avg         (win_avg),
    .min_val     (win_min),
    .max_val     (win_max)
  );

  frame_state_t      state_q, state_nx;
  logic [DATA_W-1:0] new_f   [FRAME_BYTES];
  logic [DATA_W-1:0] act_q   [FRAME_BYTES];
  logic [DATA_W-1:0] act_nx  [FRAME_BYTES];
  logic [DATA_W-1:0] pend_q  [FRAME_BYTES];
  logic [DATA_W-1:0] pend_nx [FRAME_BYTES];
  logic              pend_vld_q, pend_vld_nx;
  logic              hs, free, ovr_set;
  logic [DATA_W-1:0] data_nx;
  logic              first_nx, last_nx;
  logic [DATA_W-1:0] data_q;
  logic              first_q, last_q, overrun_q;

  assign byte_valid  = (state_q != IDLE);
  assign byte_data   = data_q;
  assign frame_first = first_q;
  assign frame_last  = last_q;
  assign overrun     = overrun_q;

  always_comb begin
    new_f[BYTE_AVG] = win_avg;
    new_f[BYTE_MIN] = win_min;
    new_f[BYTE_MAX] = win_max;
  end

  always_comb begin
    state_nx    = state_q;
    act_nx      = act_q;
    pend_nx     = pend_q;
    pend_vld_nx = pend_vld_q;
    ovr_set     = 1'b0;
    hs          = byte_valid && byte_ready;
    // The sender is free to load a frame when idle or on the final byte's handshake.
    free        = (state_q == IDLE) || ((state_q == SEND_MAX) && hs);

    if (free) begin
      if (pend_vld_q) begin
        act_nx   = pend_q;
        state_nx = SEND_AVG;
        if (win_done) begin
          pend_nx = new_f;
        end else begin
          pend_vld_nx = 1'b0;
        end
      end else if (win_done) begin
        act_nx   = new_f;
        state_nx = SEND_AVG;
      end else begin
        state_nx = IDLE;
      end
    end else begin
      if (hs) begin
        case (state_q)
          SEND_AVG: state_nx = SEND_MIN;
          SEND_MIN: state_nx = SEND_MAX;
          default:  state_nx = state_q;
        endcase
      end
      if (win_done) begin
        if (!pend_vld_q) begin
          pend_nx     = new_f;
          pend_vld_nx = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
      end
    end

    // Output bytes are registered from the next state, so they hold while stalled.
    data_nx  = '0;
    first_nx = 1'b0;
    last_nx  = 1'b0;
    case (state_nx)
      SEND_AVG: begin
        data_nx  = act_nx[BYTE_AVG];
        first_nx = 1'b1;
      end
      SEND_MIN: data_nx = act_nx[BYTE_MIN];
      SEND_MAX: begin
        data_nx = act_nx[BYTE_MAX];
        last_nx = 1'b1;
      end
      default: data_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      data_q     <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < FRAME_BYTES; i++) begin
        act_q[i]  <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      state_q    <= state_nx;
      pend_vld_q <= pend_vld_nx;
      data_q     <= data_nx;
      first_q    <= first_nx;
      last_q     <= last_nx;
      act_q      <= act_nx;
      pend_q     <= pend_nx;
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_power_frame_logger.sv
// Directed and random stimulus against a frame-queue reference model of the logger.
module tb_power_frame_logger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] sample;
  logic       byte_ready;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_first;
  logic       frame_last;
  logic       clear_overrun;
  logic       overrun;

  power_frame_logger dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .byte_ready   (byte_ready),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_first  (frame_first),
    .frame_last   (frame_last),
    .clear_overrun(clear_overrun),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef logic [23:0] frame_t;  // {avg, min, max}

  frame_t     outq[$];   // frames accepted by the logger, not yet fully sent
  logic [7:0] win[$];    // samples of the window in progress
  int         bidx;      // byte of outq[0] currently offered
  logic       m_ovr;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic frame_t stats(input logic [7:0] w[$]);
    int sum = 0;
    int mn = 255;
    int mx = 0;
    foreach (w[i]) begin
      sum += int'(w[i]);
      if (int'(w[i]) < mn) mn = int'(w[i]);
      if (int'(w[i]) > mx) mx = int'(w[i]);
    end
    return {8'(sum / 8), 8'(mn), 8'(mx)};
  endfunction

  task automatic model_reset();
    outq.delete();
    win.delete();
    bidx  = 0;
    m_ovr = 1'b0;
  endtask

  task automatic check_outputs();
    frame_t     f;
    logic [7:0] exp_b;
    chk("byte_valid", 8'(byte_valid), 8'(outq.size() > 0));
    if (outq.size() > 0) begin
      f = outq[0];
      case (bidx)
        0:       exp_b = f[23:16];
        1:       exp_b = f[15:8];
        default: exp_b = f[7:0];
      endcase
      chk("byte_data", byte_data, exp_b);
      chk("frame_first", 8'(frame_first), 8'(bidx == 0));
      chk("frame_last", 8'(frame_last), 8'(bidx == 2));
    end else begin
      chk("frame_first_idle", 8'(frame_first), 8'd0);
      chk("frame_last_idle", 8'(frame_last), 8'd0);
    end
    chk("overrun", 8'(overrun), 8'(m_ovr));
  endtask

  task automatic model_step();
    logic hs;
    logic drop;
    hs   = (outq.size() > 0) && byte_ready;
    drop = 1'b0;
    if (hs) begin
      bidx++;
      if (bidx == 3) begin
        void'(outq.pop_front());
        bidx = 0;
      end
    end
    if (sample_valid) begin
      win.push_back(sample);
      if (win.size() == 8) begin
        if (outq.size() < 2) outq.push_back(stats(win));
        else drop = 1'b1;
        win.delete();
      end
    end
    if (drop) m_ovr = 1'b1;
    else if (clear_overrun) m_ovr = 1'b0;
  endtask

  // One clock cycle: drive inputs, check registered outputs, advance the model.
  task automatic cyc(input logic sv, input logic [7:0] s, input logic rdy, input logic clr);
    sample_valid  = sv;
    sample        = s;
    byte_ready    = rdy;
    clear_overrun = clr;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 8'(byte_valid), 8'd0);
    chk({tag, "_data"}, byte_data, 8'd0);
    chk({tag, "_first"}, 8'(frame_first), 8'd0);
    chk({tag, "_last"}, 8'(frame_last), 8'd0);
    chk({tag, "_ovr"}, 8'(overrun), 8'd0);
  endtask

  task automatic rcyc();
    sample_valid  = 1'($urandom);
    sample        = 8'($urandom);
    byte_ready    = 1'($urandom);
    clear_overrun = 1'($urandom);
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic align_window();
    for (int i = 0; i < 8 && win.size() != 0; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rcyc();
    rst_n = 1'b0;

    // 7 samples: no frame yet
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    align_window();
    drain();

    // Basic frame 10..80
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(10 * i), 1'b1, 1'b0);
    drain();

    // Backpressure on the AVG byte
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(10 * i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'd0, 1'b0, 1'b0);
    drain();

    // Overrun: three windows with no ready
    for (int w = 1; w <= 3; w++)
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(w), 1'b0, 1'b0);
    chk("overrun_set", 8'(overrun), 8'd1);
    drain();
    cyc(1'b0, 8'd0, 1'b1, 1'b1);
    chk("overrun_cleared", 8'(overrun), 8'd0);

    // Value boundaries
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd255, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd0, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) cyc(1'b1, (i % 2 == 0) ? 8'd0 : 8'd255, 1'b1, 1'b0);
    drain();

    // Completion on the MAX handshake, pending slot empty
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'(i >= 5), 1'b0);
    drain();

    // Completion on the MAX handshake, pending slot full
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'(i >= 5), 1'b0);
    chk("no_overrun_on_handoff", 8'(overrun), 8'd0);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 5),
          1'($urandom_range(0, 19) == 0));
    drain();
    for (int i = 0; i < 200; i++)
      cyc(1'b1, 8'($urandom), 1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 29) == 0));
    drain();

    // Reset during SEND_MIN with a pending frame
    align_window();
    drain();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rcyc();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/power_frame_logger.md
Name: power_frame_logger

Overview:
Downstream data stage of the power converter. Consumes the converter's 8-bit output samples and accumulates them over a fixed window of 2^LOG2_WIN accepted samples. At each window end it emits a 3-byte statistics frame (average, minimum, maximum) on a byte stream with a valid/ready handshake. One frame is double-buffered, and overruns are flagged.

Parameters:
DATA_W, 8, sample and byte width
LOG2_WIN, 3, log2 of window length (default window = 8 samples)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
sample_valid  input  1  sample qualifier; a sample is accepted every cycle this is high (no backpressure)
sample  input  DATA_W  converter output value
byte_ready  input  1  downstream can accept byte
byte_valid  output  1  byte_data holds a valid frame byte
byte_data  output  DATA_W  frame byte
frame_first  output  1  high with the AVG byte
frame_last  output  1  high with the MAX byte
clear_overrun  input  1  synchronous clear of overrun
overrun  output  1  sticky: a completed window was dropped

Behaviour:
Reset and clock:
- Clock clk; reset rst_n, asynchronous, active-high.
- While rst_n=1: all outputs 0, FSM IDLE, accumulator 0, sample count 0, min register all-ones, max register 0, pending slot empty.

Window accumulation:
- Accumulator width is DATA_W+LOG2_WIN, so it never overflows.
- Count runs 0..2^LOG2_WIN-1 and wraps.
- The sample that brings the count to the last value (the window-completing sample) is included in that window's stats.
- At completion:
  - avg = (acc+sample)>>LOG2_WIN, truncated.
  - min and max include this sample.
  - acc, min and max reinitialise so the next window starts empty.
- Completion cycle t: the frame is available on byte_valid from cycle t+1 if the sender is free.

Frame FSM states: IDLE, SEND_AVG, SEND_MIN, SEND_MAX.
- IDLE -> SEND_AVG on window completion, or if the pending slot is full.
- SEND_x advances on byte_valid & byte_ready.
- SEND_MAX on handshake -> SEND_AVG if the pending slot is full or a window completes in the same cycle; otherwise -> IDLE.
- byte_valid=1 exactly in SEND states.
- byte_data, frame_first and frame_last are registered and held stable while byte_valid & !byte_ready.
- frame_first=1 only in SEND_AVG; frame_last=1 only in SEND_MAX.

Buffering (one active frame plus one pending slot):
- Window completes while sending and the pending slot is empty -> store in pending.
- Pending slot full and no final handshake this cycle -> new window dropped, overrun<=1. Accumulator still restarts.
- Completion in the same cycle as the SEND_MAX handshake with the pending slot full:
  - pending frame moves to active;
  - new frame moves to pending;
  - no overrun.
- Completion in the same cycle as the SEND_MAX handshake with the pending slot empty: new frame goes directly to active.
- Frames are emitted strictly in completion order.

Overrun:
- overrun is sticky and cleared by clear_overrun the next cycle.
- Set has priority if set and clear occur in the same cycle.

Reset mid-frame: outputs drop immediately (async). Partial window and pending frame are discarded.

Decomposition:
- Package power_data_pkg:
  - frame state enum (IDLE, SEND_AVG, SEND_MIN, SEND_MAX);
  - byte index constants;
  - min/max initial value constants.
- Sub-module window_stats: accumulator, counter, min/max, avg computation, and the single-cycle done pulse with avg/min/max outputs.
- The top level holds the FSM, frame slots and overrun logic.

Test Plan:
1. Reset: hold rst_n=1 with random inputs -> all outputs 0. Release, feed 7 samples -> byte_valid stays 0.
2. Basic frame: samples 10,20,...,80 back-to-back, byte_ready=1 -> byte_valid rises the cycle after the 8th sample. Bytes 45 (first=1), 10, 80 (last=1), then byte_valid=0.
3. Backpressure: as in scenario 2 but byte_ready=0 for 5 cycles -> byte_data stays 45 with frame_first=1 throughout. Then 10 and 80 follow once ready rises.
4. Overrun: byte_ready=0, feed 24 samples forming 3 windows (all 1s, all 2s, all 3s) -> overrun=1. Raise ready -> exactly 6 bytes: 1,1,1,2,2,2. Pulse clear_overrun -> overrun=0.
5. Boundaries: window of all 255 -> 255,255,255. Window of all 0 -> 0,0,0. Mixed 0/255 alternating -> avg 127, min 0, max 255. Window completing exactly on the SEND_MAX handshake -> next frame starts the following cycle with no gap and no overrun.
6. Reset mid-operation: assert rst_n during SEND_MIN with a pending frame -> byte_valid=0 immediately. After release, the first frame out comes from 8 fresh samples only.
